// File: rtl/bcd_mod_counter_if.sv
// Bundles the control, load and status signals of one BCD counter field.
// The clock and reset stay outside as plain ports.
interface bcd_mod_counter_if #(
    parameter int DIGITS = 2
);
    logic                  ena;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   d;
    logic [4*DIGITS-1:0]   q;
    logic                  out;
    logic                  load_err;

    modport master (output ena, up, load, d, input q, out, load_err);
    modport slave  (input ena, up, load, d, output q, out, load_err);
endinterface

// File: rtl/bcd_mod_counter.sv
// BCD up/down counter over MIN_VAL..MAX_VAL with a validated parallel load.
// It also registers a wrap pulse that the next time field uses as its enable.
module bcd_mod_counter #(
    parameter int DIGITS  = 2,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 59
) (
    input  logic              clk,
    input  logic              reset,
    bcd_mod_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    if (DIGITS < 1 || DIGITS > 4 || MIN_VAL < 0 || MIN_VAL > MAX_VAL || MAX_VAL >= 10**DIGITS) begin : g_bad_params
        $error("bcd_mod_counter: illegal DIGITS/MIN_VAL/MAX_VAL");
    end

    logic [W-1:0] q_q, q_d;
    logic         out_q, out_d;
    logic         err_q, err_d;
    logic [W-1:0] inc_v, dec_v;
    logic         cy, bw, nib_ok;
    logic         min_ok, max_ok, load_ok;

    // Per-digit ripple: a digit only moves if every lower digit wrapped.
    always_comb begin
        inc_v  = '0;
        dec_v  = '0;
        cy     = 1'b1;
        bw     = 1'b1;
        nib_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!cy)                        inc_v[4*i +: 4] = q_q[4*i +: 4];
            else if (q_q[4*i +: 4] == 4'd9) inc_v[4*i +: 4] = 4'd0;
            else begin
                inc_v[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
                cy              = 1'b0;
            end
            if (!bw)                        dec_v[4*i +: 4] = q_q[4*i +: 4];
            else if (q_q[4*i +: 4] == 4'd0) dec_v[4*i +: 4] = 4'd9;
            else begin
                dec_v[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
                bw              = 1'b0;
            end
            if (bus.d[4*i +: 4] > 4'd9) nib_ok = 1'b0;
        end
    end

    // With all nibbles valid, BCD order equals unsigned vector order.
    if (MIN_VAL > 0) begin : g_min_chk
        assign min_ok = (bus.d >= MIN_BCD);
    end else begin : g_min_free
        assign min_ok = 1'b1;
    end
    assign max_ok  = (bus.d <= MAX_BCD);
    assign load_ok = nib_ok && min_ok && max_ok;

    always_comb begin
        q_d   = q_q;
        out_d = 1'b0;
        err_d = 1'b0;
        if (bus.load) begin
            if (load_ok) q_d   = bus.d;
            else         err_d = 1'b1;
        end else if (bus.ena) begin
            if (bus.up) begin
                if (q_q == MAX_BCD) begin
                    q_d   = MIN_BCD;
                    out_d = 1'b1;
                end else begin
                    q_d = inc_v;
                end
            end else begin
                if (q_q == MIN_BCD) begin
                    q_d   = MAX_BCD;
                    out_d = 1'b1;
                end else begin
                    q_d = dec_v;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q   <= MIN_BCD;
            out_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            out_q <= out_d;
            err_q <= err_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.out      = out_q;
    assign bus.load_err = err_q;
endmodule
